// File: rtl/if_pkg.sv
// Shared types and widths for the instruction-fetch stage.
package if_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/if_fetch_unit_hold_buf.sv
// One-entry holding buffer for a fetched {pc, instr} pair while decode is stalled.
// Clear wins over load if both are asserted in the same cycle.
module if_hold_buf
    import if_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       clear_i,
    input  fetch_pkt_t pkt_i,
    output fetch_pkt_t pkt_o,
    output logic       valid_o
);

    fetch_pkt_t pkt_q;
    logic       valid_q;

    // Entry storage: capture on load, invalidate on clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_q   <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            pkt_q   <= pkt_i;
            valid_q <= 1'b1;
        end
    end

    assign pkt_o   = pkt_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time, and drives the producer side of the IF/ID register.
//
// state | meaning
// IDLE  | one cycle after reset release
// REQ   | request valid on imem, waiting for ready
// WAIT  | request accepted, waiting for response (drop_q = discard it)
// HOLD  | fetched instruction parked in the buffer while decode stalls
//
// Optional build macro IF_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 64'h0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               ifid_write,
    output logic               ifid_flush
`ifdef IF_PERF_CNT_EN
    ,
    output logic [63:0]        perf_fetched,
    output logic [63:0]        perf_bubbles
`endif
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            hs;
    logic            buf_load, buf_clear, buf_valid;
    logic            present_rsp, present_buf, bubble;
    fetch_pkt_t      buf_pkt;

    // pc_q always equals the address of the current/outstanding request.
    assign hs             = (state_q == REQ) && imem_req_ready;
    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;

    // State, PC and drop flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic; a redirect overrides stall and any response.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        present_rsp = 1'b0;
        present_buf = 1'b0;
        bubble      = 1'b0;
        if (branch_taken) begin
            pc_d      = branch_target;
            buf_clear = 1'b1;
            case (state_q)
                REQ: begin
                    if (hs) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: begin
                    drop_d  = 1'b0;
                    state_d = REQ;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = REQ;
                    bubble  = !stall;
                end
                REQ: begin
                    if (hs) state_d = WAIT;
                    bubble = !stall;
                end
                WAIT: begin
                    if (imem_rsp_valid && drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                        bubble  = !stall;
                    end else if (imem_rsp_valid && !stall) begin
                        present_rsp = 1'b1;
                        pc_d        = pc_q + PC_W'(PC_STEP);
                        state_d     = REQ;
                    end else if (imem_rsp_valid) begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + PC_W'(PC_STEP);
                        state_d  = HOLD;
                    end else begin
                        bubble = !stall;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        present_buf = buf_valid;
                        bubble      = !buf_valid;
                        buf_clear   = 1'b1;
                        state_d     = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // IF/ID payload: live response, parked buffer entry, or zeros.
    always_comb begin
        if_pc    = '0;
        if_instr = '0;
        if (present_rsp) begin
            if_pc    = pc_q;
            if_instr = imem_rsp_data;
        end else if (present_buf) begin
            if_pc    = buf_pkt.pc;
            if_instr = buf_pkt.instr;
        end
    end

    assign ifid_write = present_rsp | present_buf;
    assign ifid_flush = reset | branch_taken | bubble;

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .reset   (reset),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pkt_i   ('{pc: pc_q, instr: imem_rsp_data}),
        .pkt_o   (buf_pkt),
        .valid_o (buf_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [63:0] fetched_q, bubbles_q;

    // Event counters; redirect flushes are not counted as bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (ifid_write) fetched_q <= fetched_q + 64'd1;
            if (bubble)     bubbles_q <= bubbles_q + 64'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable imem model.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        ifid_write;
    logic        ifid_flush;
`ifdef IF_PERF_CNT_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_bubbles;
`endif

    int tests = 0;
    int fails = 0;
    int exp_fetched = 0;
    int exp_bubbles = 0;

    int          mem_lat;
    logic        pend;
    int          pend_cnt;
    logic [63:0] pend_addr;

    if_fetch_unit #(.RESET_PC(64'h0), .PC_STEP(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0013;
    endfunction

    // Memory: response mem_lat cycles after acceptance (1 = next cycle).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            pend           <= 1'b0;
            pend_cnt       <= 0;
            pend_addr      <= '0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (pend) begin
                if (pend_cnt == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(pend_addr);
                    pend           <= 1'b0;
                end else begin
                    pend_cnt <= pend_cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (mem_lat <= 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(imem_req_addr);
                end else begin
                    pend      <= 1'b1;
                    pend_cnt  <= mem_lat - 1;
                    pend_addr <= imem_req_addr;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven at the negedge; check, then advance.
    task automatic cyc(input string tag, input logic ev, input logic [63:0] ea,
                       input logic ew, input logic ef, input logic [63:0] epc);
        #1;
        chk({tag, ".req_valid"}, 64'(imem_req_valid), 64'(ev));
        if (ev) chk({tag, ".req_addr"}, imem_req_addr, ea);
        chk({tag, ".ifid_write"}, 64'(ifid_write), 64'(ew));
        chk({tag, ".ifid_flush"}, 64'(ifid_flush), 64'(ef));
        if (ew) begin
            chk({tag, ".if_pc"}, if_pc, epc);
            chk({tag, ".if_instr"}, 64'(if_instr), 64'(mem_word(epc)));
        end
        if (ew) exp_fetched++;
        if (ef && !branch_taken) exp_bubbles++;
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = '0;
        imem_req_ready = 1'b1;
        mem_lat        = 1;

        @(negedge clk);
        #1;
        chk("rst.req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst.ifid_write", 64'(ifid_write), 64'd0);
        chk("rst.ifid_flush", 64'(ifid_flush), 64'd1);
        chk("rst.if_pc", if_pc, 64'd0);
        chk("rst.if_instr", 64'(if_instr), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Sequential fetches, always-ready memory, 1-cycle response.
        cyc("idle", 0, 0, 0, 1, 0);
        cyc("req0", 1, 64'h0, 0, 1, 0);
        cyc("rsp0", 0, 0, 1, 0, 64'h0);
        cyc("req4", 1, 64'h4, 0, 1, 0);
        cyc("rsp4", 0, 0, 1, 0, 64'h4);
        cyc("req8", 1, 64'h8, 0, 1, 0);

        // Response for 0x8 lands during a 3-cycle stall.
        stall = 1'b1;
        cyc("stl0", 0, 0, 0, 0, 0);
        cyc("stl1", 0, 0, 0, 0, 0);
        cyc("stl2", 0, 0, 0, 0, 0);
        stall = 1'b0;
        cyc("hold8", 0, 0, 1, 0, 64'h8);
        cyc("reqC", 1, 64'hC, 0, 1, 0);
        cyc("rspC", 0, 0, 1, 0, 64'hC);

        // Redirect while waiting for a slow 0x10 response; that response is dropped.
        mem_lat = 3;
        cyc("req10", 1, 64'h10, 0, 1, 0);
        branch_taken = 1'b1; branch_target = 64'h100;
        cyc("br_wait", 0, 0, 0, 1, 0);
        branch_taken = 1'b0;
        cyc("drop_w", 0, 0, 0, 1, 0);
        cyc("drop_rsp", 0, 0, 0, 1, 0);
        mem_lat = 1;
        cyc("req100", 1, 64'h100, 0, 1, 0);
        cyc("rsp100", 0, 0, 1, 0, 64'h100);

        // Redirect during HOLD discards the buffered 0x104.
        cyc("req104", 1, 64'h104, 0, 1, 0);
        stall = 1'b1;
        cyc("stl104", 0, 0, 0, 0, 0);
        branch_taken = 1'b1; branch_target = 64'h200;
        cyc("br_hold", 0, 0, 0, 1, 0);
        branch_taken = 1'b0; stall = 1'b0;

        // Memory not ready for 4 cycles: request held stable.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("nrdy", 1, 64'h200, 0, 1, 0);
        imem_req_ready = 1'b1;
        cyc("req200", 1, 64'h200, 0, 1, 0);
        cyc("rsp200", 0, 0, 1, 0, 64'h200);

        // Redirect in REQ without handshake, to the top of the address space.
        imem_req_ready = 1'b0;
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc("br_req", 1, 64'h204, 0, 1, 0);
        branch_taken = 1'b0; imem_req_ready = 1'b1;
        cyc("reqTop", 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0);
        cyc("rspTop", 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC);

        // PC wrapped to 0; redirect coincides with the handshake -> drop.
        branch_taken = 1'b1; branch_target = 64'h300;
        cyc("br_hs", 1, 64'h0, 0, 1, 0);
        branch_taken = 1'b0;
        cyc("drop_hs", 0, 0, 0, 1, 0);
        cyc("req300", 1, 64'h300, 0, 1, 0);
        cyc("rsp300", 0, 0, 1, 0, 64'h300);
        cyc("req304", 1, 64'h304, 0, 1, 0);
        cyc("rsp304", 0, 0, 1, 0, 64'h304);
        cyc("req308", 1, 64'h308, 0, 1, 0);
        cyc("rsp308", 0, 0, 1, 0, 64'h308);

`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 64'd10);
        chk("perf_bubbles", perf_bubbles, 64'(exp_bubbles));
        chk("fetched_tally", 64'(exp_fetched), 64'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
